// File: rtl/msg_bus_rr_arbiter_if.sv
// Message-bus bundle between NB_MASTERS core-side masters, the arbiter
// and one message-bus slave.
// Ports: m_* are the per-master request/grant/response signals,
// s_* are the single slave-side request/grant/response signals.
// Modport slave is the arbiter's view and modport master is the
// environment's view (the masters plus the bus slave).
interface msg_bus_rr_arbiter_if #(
    parameter int NB_MASTERS = 8,
    parameter int ID_WIDTH   = 9
);
    logic [NB_MASTERS-1:0]          m_req_i;
    logic [NB_MASTERS*32-1:0]       m_add_i;
    logic [NB_MASTERS-1:0]          m_wen_i;
    logic [NB_MASTERS*32-1:0]       m_wdata_i;
    logic [NB_MASTERS*4-1:0]        m_be_i;
    logic [NB_MASTERS*ID_WIDTH-1:0] m_id_i;
    logic [NB_MASTERS-1:0]          m_gnt_o;
    logic [NB_MASTERS-1:0]          m_r_valid_o;
    logic                           m_r_opc_o;
    logic [ID_WIDTH-1:0]            m_r_id_o;
    logic [31:0]                    m_r_rdata_o;

    logic                           s_req_o;
    logic [31:0]                    s_add_o;
    logic                           s_wen_o;
    logic [31:0]                    s_wdata_o;
    logic [3:0]                     s_be_o;
    logic [ID_WIDTH-1:0]            s_id_o;
    logic                           s_gnt_i;
    logic                           s_r_valid_i;
    logic                           s_r_opc_i;
    logic [ID_WIDTH-1:0]            s_r_id_i;
    logic [31:0]                    s_r_rdata_i;

    modport slave (
        input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i, m_id_i,
        output m_gnt_o, m_r_valid_o, m_r_opc_o, m_r_id_o, m_r_rdata_o,
        output s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o, s_id_o,
        input  s_gnt_i, s_r_valid_i, s_r_opc_i, s_r_id_i, s_r_rdata_i
    );

    modport master (
        output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i, m_id_i,
        input  m_gnt_o, m_r_valid_o, m_r_opc_o, m_r_id_o, m_r_rdata_o,
        input  s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o, s_id_o,
        output s_gnt_i, s_r_valid_i, s_r_opc_i, s_r_id_i, s_r_rdata_i
    );
endinterface

// File: rtl/msg_bus_rr_arbiter.sv
// N-to-1 round-robin message-bus arbiter with a single request slot,
// an outstanding-transaction limit and one-hot r_id response routing.
// Ports: clk_i, rst_i (sync, active high), bus (slave modport).
// Define MSG_BUS_ARB_RSP_REG_EN to register all response outputs.
module msg_bus_rr_arbiter #(
    parameter int NB_MASTERS      = 8,
    parameter int ID_WIDTH        = 9,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    msg_bus_rr_arbiter_if.slave bus
);
    localparam int PW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
    localparam int CW = 5;

    logic [31:0]         add_a   [NB_MASTERS];
    logic [31:0]         wdata_a [NB_MASTERS];
    logic [3:0]          be_a    [NB_MASTERS];
    logic [ID_WIDTH-1:0] id_a    [NB_MASTERS];

    for (genvar g = 0; g < NB_MASTERS; g++) begin : g_unpack
        assign add_a[g]   = bus.m_add_i[g*32 +: 32];
        assign wdata_a[g] = bus.m_wdata_i[g*32 +: 32];
        assign be_a[g]    = bus.m_be_i[g*4 +: 4];
        assign id_a[g]    = bus.m_id_i[g*ID_WIDTH +: ID_WIDTH];
    end

    logic                slot_vld;
    logic [31:0]         slot_add;
    logic                slot_wen;
    logic [31:0]         slot_wdata;
    logic [3:0]          slot_be;
    logic [ID_WIDTH-1:0] slot_id;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;
    logic          hand;
    logic          accept;
    logic          grant;
    logic [CW-1:0] cnt;
    logic          dec_v;

    assign hand = slot_vld & bus.s_gnt_i;

    // A slot entry handed over this cycle joins cnt at the edge, so an
    // occupied slot always holds one credit; this keeps the number of
    // slave-accepted requests at or below MAX_OUTSTANDING.
    assign accept = !rst_i && (!slot_vld || hand) &&
                    ((cnt + CW'(slot_vld)) < CW'(MAX_OUTSTANDING));

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NB_MASTERS; k++) begin
            idx = PW'((int'(ptr) + k) % NB_MASTERS);
            if (!found && bus.m_req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant = accept & found;

    always_comb begin
        bus.m_gnt_o = '0;
        if (grant) bus.m_gnt_o[win] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_vld   <= 1'b0;
            slot_add   <= '0;
            slot_wen   <= 1'b0;
            slot_wdata <= '0;
            slot_be    <= '0;
            slot_id    <= '0;
            ptr        <= '0;
        end else if (grant) begin
            slot_vld   <= 1'b1;
            slot_add   <= add_a[win];
            slot_wen   <= bus.m_wen_i[win];
            slot_wdata <= wdata_a[win];
            slot_be    <= be_a[win];
            slot_id    <= id_a[win];
            ptr        <= (win == PW'(NB_MASTERS - 1)) ? '0 : win + 1'b1;
        end else if (hand) begin
            slot_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (hand && !dec_v) begin
            cnt <= cnt + 1'b1;
        end else if (!hand && dec_v && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign bus.s_req_o   = slot_vld;
    assign bus.s_add_o   = slot_add;
    assign bus.s_wen_o   = slot_wen;
    assign bus.s_wdata_o = slot_wdata;
    assign bus.s_be_o    = slot_be;
    assign bus.s_id_o    = slot_id;

`ifdef MSG_BUS_ARB_RSP_REG_EN
    logic                rv_q;
    logic                opc_q;
    logic [ID_WIDTH-1:0] rid_q;
    logic [31:0]         rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rv_q    <= 1'b0;
            opc_q   <= 1'b0;
            rid_q   <= '0;
            rdata_q <= '0;
        end else begin
            rv_q    <= bus.s_r_valid_i;
            opc_q   <= bus.s_r_opc_i;
            rid_q   <= bus.s_r_id_i;
            rdata_q <= bus.s_r_rdata_i;
        end
    end

    assign bus.m_r_valid_o = {NB_MASTERS{rv_q}} & rid_q[NB_MASTERS-1:0];
    assign bus.m_r_opc_o   = opc_q;
    assign bus.m_r_id_o    = rid_q;
    assign bus.m_r_rdata_o = rdata_q;
    assign dec_v           = rv_q;
`else
    assign bus.m_r_valid_o = {NB_MASTERS{bus.s_r_valid_i}} &
                             bus.s_r_id_i[NB_MASTERS-1:0];
    assign bus.m_r_opc_o   = bus.s_r_opc_i;
    assign bus.m_r_id_o    = bus.s_r_id_i;
    assign bus.m_r_rdata_o = bus.s_r_rdata_i;
    assign dec_v           = bus.s_r_valid_i;
`endif
endmodule
